// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   XLEN          : architectural register / address width
//   RESET_VECTOR  : PC value loaded on reset
//   NOP_INSTR     : canonical bubble (addi x0,x0,0) shown when decode is empty
//   fetch_state_e : fetch-stage FSM encoding
//   fetch_entry_t : one {pc, instr} pair travelling to decode
//   align_pc      : forces a redirect target onto a 4-byte boundary
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_fetch_if.sv
// Fetch -> decode handshake bundle.
//   valid : fetch holds a {pc, instr} pair for decode
//   ready : decode accepts the pair on the rising edge where valid && ready
//   pc    : PC of instr
//   instr : fetched instruction word (NOP_INSTR when valid=0)
// master = fetch side, slave = decode side.
interface if_pc_fetch_if;
  import riscv_pkg::*;

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;

  modport master (output valid, output pc, output instr, input ready);
  modport slave  (input valid, input pc, input instr, output ready);

endinterface

// File: rtl/if_skid_buffer.sv
// One-entry {pc, instr} skid buffer that catches an instruction returning from
// memory while the decode output register is stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : load push_entry (wins over pop in the same cycle)
//   pop        : release the held entry
//   flush      : discard the held entry (highest priority)
//   push_entry : incoming {pc, instr}
//   valid      : an entry is held
//   entry      : the held {pc, instr}
module if_skid_buffer
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic         valid,
  output fetch_entry_t entry
);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      // NOTE: the data half is reset too so a freshly reset stage never
      // presents X on its outputs; it is one entry, not a memory array.
      entry <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      entry <= push_entry;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_pc_fetch.sv
// Instruction fetch stage sitting directly upstream of the external PC_ADDER.
// Holds the architectural PC, issues single-cycle-latency instruction memory
// reads, and hands {pc, instr} to decode over a valid/ready handshake with a
// one-entry skid so no returning instruction is lost during a decode stall.
// Branch/jump redirects flush everything in flight.
//   clk, rst_n     : clock, asynchronous active-low reset
//   pc_itself      : current PC, to PC_ADDER.PC_itself
//   pc_plus4       : PC_ADDER.pc (pc_itself + 4, wraps mod 2^32)
//   redirect_valid : taken branch/jump this cycle, overrides everything
//   redirect_pc    : redirect target (low two bits ignored, flagged if set)
//   imem_req       : read request; data returns on imem_rdata next cycle
//   imem_addr      : read address (equals pc_itself)
//   imem_rdata     : instruction for the previous cycle's request
//   id             : decode handshake (valid/ready/pc/instr)
//   fetch_fault    : one-cycle pulse after a misaligned redirect
module if_pc_fetch
  import riscv_pkg::XLEN, riscv_pkg::fetch_state_e, riscv_pkg::fetch_entry_t,
         riscv_pkg::align_pc, riscv_pkg::IDLE, riscv_pkg::FETCH, riscv_pkg::HOLD;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR,
  parameter logic [XLEN-1:0] NOP_INSTR    = riscv_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [XLEN-1:0]      pc_itself,
  input  logic [XLEN-1:0]      pc_plus4,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic [XLEN-1:0]      imem_rdata,
  if_pc_fetch_if.master        id,
  output logic                 fetch_fault
);

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: '0, instr: NOP_INSTR};

  fetch_state_e    state, state_next;

  logic            pc_q;
  logic [XLEN-1:0] pc_reg;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic            out_valid;
  fetch_entry_t    out_entry;
  logic            fault_q;

  logic            skid_valid;
  fetch_entry_t    skid_entry;
  logic            skid_push;
  logic            skid_pop;
  logic            skid_valid_next;

  logic            issue;
  logic            ret;
  logic            out_free;
  fetch_entry_t    ret_entry;

  assign pc_q = 1'b0;

  // A redirect kills the response arriving this cycle: the request was for
  // the old path. Since a response always lands exactly one cycle after its
  // request, suppressing capture here is the whole kill mechanism.
  assign ret       = inflight && !redirect_valid;
  assign ret_entry = '{pc: inflight_pc, instr: imem_rdata};
  assign out_free  = !out_valid || id.ready;

  // Next state, issue decision and skid control.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_next      = state;
    issue           = 1'b0;
    skid_push       = 1'b0;
    skid_pop        = 1'b0;
    skid_valid_next = skid_valid;

    // Issue only when the returning word is guaranteed a slot: the skid is
    // empty, and we are not about to fill it with a response that the stalled
    // output register cannot take. This caps storage at two entries.
    if (state == FETCH) begin
      issue = !skid_valid && !(out_valid && !id.ready && inflight) && !redirect_valid;
    end

    if (!redirect_valid) begin
      if (out_free) begin
        skid_pop  = skid_valid;
        skid_push = ret && skid_valid;
      end else begin
        skid_push = ret;
      end
    end

    if (redirect_valid)  skid_valid_next = 1'b0;
    else if (skid_push)  skid_valid_next = 1'b1;
    else if (skid_pop)   skid_valid_next = 1'b0;

    case (state)
      IDLE:        state_next = FETCH;
      FETCH, HOLD: state_next = skid_valid_next ? HOLD : FETCH;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // PC register and the single outstanding-request tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc_reg;

      if (redirect_valid) pc_reg <= align_pc(redirect_pc);
      else if (issue)     pc_reg <= pc_plus4;
    end
  end

  // Decode-facing output register. When the current entry leaves, the skid
  // refills it first (it is older than any return), else the return does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_entry <= EMPTY_ENTRY;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
      out_entry <= EMPTY_ENTRY;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_entry <= skid_entry;
      end else if (ret) begin
        out_valid <= 1'b1;
        out_entry <= ret_entry;
      end else begin
        out_valid <= 1'b0;
        out_entry <= EMPTY_ENTRY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end

  if_skid_buffer u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (skid_push),
    .pop        (skid_pop),
    .flush      (redirect_valid),
    .push_entry (ret_entry),
    .valid      (skid_valid),
    .entry      (skid_entry)
  );

  assign pc_itself   = pc_reg;
  assign imem_req    = issue;
  assign imem_addr   = pc_reg;
  assign id.valid    = out_valid;
  assign id.pc       = out_entry.pc;
  assign id.instr    = out_entry.instr;
  assign fetch_fault = fault_q | pc_q;

endmodule

// File: tb/tb_if_pc_fetch.sv
// Directed bench for if_pc_fetch: models PC_ADDER and a one-cycle-latency
// instruction memory whose words are a bijective function of the address.
module tb_if_pc_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_itself;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  if_pc_fetch_if id_bus ();

  if_pc_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_itself      (pc_itself),
    .pc_plus4       (pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id             (id_bus),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // PC_ADDER model.
  assign pc_plus4 = pc_itself + 32'd4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory holds its last word when not requested, so a stale word is present
  // on imem_rdata whenever the stage must ignore it.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next accepted decode handshake and compare it.
  task automatic expect_accept(input string tag, input logic [31:0] exp_pc);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (id_bus.valid && id_bus.ready) begin
        got = 1'b1;
        check({tag, "_pc"}, id_bus.pc, exp_pc);
        check({tag, "_instr"}, id_bus.instr, mem_word(exp_pc));
      end
      tick();
    end
    check({tag, "_seen"}, {31'd0, got}, 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp_pc);
    check({tag, "_valid"}, {31'd0, id_bus.valid}, 32'd1);
    check({tag, "_pc"}, id_bus.pc, exp_pc);
    check({tag, "_instr"}, id_bus.instr, mem_word(exp_pc));
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_pc_itself"}, pc_itself, 32'h0);
    check({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_id_valid"}, {31'd0, id_bus.valid}, 32'd0);
    check({tag, "_id_pc"}, id_bus.pc, 32'h0);
    check({tag, "_id_instr"}, id_bus.instr, NOP);
    check({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_bus.ready   = 1'b1;

    // 1: reset, start-up latency, back-to-back stream.
    #12;
    expect_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();                                   // IDLE -> FETCH
    check("start_req", {31'd0, imem_req}, 32'd1);
    check("start_addr", imem_addr, 32'h0);
    check("start_valid0", {31'd0, id_bus.valid}, 32'd0);
    tick();                                   // issue 0x0
    check("start_valid1", {31'd0, id_bus.valid}, 32'd0);
    check("start_pc4", pc_itself, 32'h4);
    tick();                                   // return 0x0
    expect_out("s0", 32'h0);
    tick();
    expect_out("s4", 32'h4);
    tick();
    expect_out("s8", 32'h8);
    tick();
    expect_out("s12", 32'hC);

    // 2: five-cycle decode stall; two entries buffered, then resume.
    id_bus.ready = 1'b0;
    #1;
    check("stall_noissue", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold_pc", id_bus.pc, 32'hC);
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    check("stall_skid_full", {31'd0, dut.skid_valid}, 32'd1);
    id_bus.ready = 1'b1;
    expect_accept("resume_a", 32'hC);
    expect_accept("resume_b", 32'h10);
    expect_accept("resume_c", 32'h14);
    expect_accept("resume_d", 32'h18);

    // 3: redirect while output and skid are both full.
    id_bus.ready = 1'b0;
    tick();
    tick();
    tick();
    check("pre_redir_skid", {31'd0, dut.skid_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    id_bus.ready   = 1'b1;
    #1;
    check("redir_noissue", {31'd0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir_flush_valid", {31'd0, id_bus.valid}, 32'd0);
    check("redir_pc", pc_itself, 32'h100);
    check("redir_req", {31'd0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_fault", {31'd0, fetch_fault}, 32'd0);
    tick();
    check("redir_gap", {31'd0, id_bus.valid}, 32'd0);
    tick();
    expect_out("redir_t0", 32'h100);
    tick();
    expect_out("redir_t1", 32'h104);

    // 4: misaligned redirect, with a response in flight.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("mis_fault_hi", {31'd0, fetch_fault}, 32'd1);
    check("mis_pc", pc_itself, 32'h100);
    check("mis_valid0", {31'd0, id_bus.valid}, 32'd0);
    tick();
    check("mis_fault_lo", {31'd0, fetch_fault}, 32'd0);
    check("mis_valid1", {31'd0, id_bus.valid}, 32'd0);
    tick();
    expect_out("mis_t0", 32'h100);
    tick();
    expect_out("mis_t1", 32'h104);

    // 5: redirect to the top of the address space and wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wrap_fault0", {31'd0, fetch_fault}, 32'd0);
    check("wrap_pc", pc_itself, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc_next", pc_itself, 32'h0);
    tick();
    expect_out("wrap_top", 32'hFFFF_FFFC);
    check("wrap_fault1", {31'd0, fetch_fault}, 32'd0);
    tick();
    expect_out("wrap_zero", 32'h0);

    // 6: asynchronous reset mid-stream, off the clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    expect_reset_outputs("async_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();                                   // IDLE -> FETCH
    check("rst_idle_valid", {31'd0, id_bus.valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'h0);
    tick();                                   // issue 0x0, stale word ignored
    check("rst_stale", {31'd0, id_bus.valid}, 32'd0);
    tick();
    expect_out("rst_t0", 32'h0);
    tick();
    expect_out("rst_t1", 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
